// File: rtl/oserdes_rx_checker.sv
// Receive checker for OSERDES loopback: deserializes the pin stream MSB-first, bit-slips
// onto an incrementing ramp, then tracks lock and word errors. Macro OSERDES_RX_CHECKER_STICKY_ERROR_EN latches ERROR.
module oserdes_rx_checker #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             I_CE,
    input  logic             I_DAT,
    output logic [WIDTH-1:0] O_WORD,
    output logic             O_STB,
    output logic             LOCKED,
    output logic             ERROR,
    output logic [15:0]      ERR_CNT
);
    localparam int unsigned   CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
    localparam logic [3:0]    LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0]    UNLOCK_N = 4'(UNLOCK_CNT);

    typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             slip_q, slip_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       bad_q, bad_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             stb_q, stb_d;
    logic             err_q, err_d;
    logic [15:0]      ecnt_q, ecnt_d;
    logic [WIDTH-1:0] word;

    // Candidate word if this enabled bit completes it.
    assign word = {sr_q, I_DAT};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        slip_d  = slip_q;
        exp_d   = exp_q;
        match_d = match_q;
        bad_d   = bad_q;
        word_d  = word_q;
        stb_d   = 1'b0;
        ecnt_d  = ecnt_q;
`ifdef OSERDES_RX_CHECKER_STICKY_ERROR_EN
        err_d   = err_q;
`else
        err_d   = 1'b0;
`endif
        if (I_CE) begin
            sr_d = word[WIDTH-2:0];
            if (slip_q) begin
                // Held count stretches this word by one bit, moving the boundary later.
                slip_d = 1'b0;
            end else if (cnt_q != LAST) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d  = '0;
                word_d = word;
                stb_d  = 1'b1;
                case (state_q)
                    ST_SEARCH: begin
                        exp_d = word + WIDTH'(1);
                        if (word == exp_q) begin
                            if (match_q + 4'd1 == LOCK_N) begin
                                state_d = ST_LOCKED;
                                match_d = '0;
                                bad_d   = '0;
                            end else begin
                                match_d = match_q + 4'd1;
                            end
                        end else begin
                            match_d = '0;
                            slip_d  = 1'b1;
                        end
                    end
                    default: begin
                        exp_d = exp_q + WIDTH'(1);
                        if (word == exp_q) begin
                            bad_d = '0;
                        end else begin
                            err_d = 1'b1;
                            if (ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
                            if (bad_q + 4'd1 == UNLOCK_N) begin
                                state_d = ST_SEARCH;
                                match_d = '0;
                                slip_d  = 1'b1;
                                exp_d   = word + WIDTH'(1);
                            end
                            bad_d = bad_q + 4'd1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_SEARCH;
            sr_q    <= '0;
            cnt_q   <= '0;
            slip_q  <= 1'b0;
            exp_q   <= '0;
            match_q <= '0;
            bad_q   <= '0;
            word_q  <= '0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            slip_q  <= slip_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            bad_q   <= bad_d;
            word_q  <= word_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign O_WORD  = word_q;
    assign O_STB   = stb_q;
    assign LOCKED  = (state_q == ST_LOCKED);
    assign ERROR   = err_q;
    assign ERR_CNT = ecnt_q;

endmodule

// File: tb/tb_oserdes_rx_checker.sv
// Directed bench for oserdes_rx_checker (WIDTH=4, LOCK_CNT=4, UNLOCK_CNT=2) with a word scoreboard.
module tb_oserdes_rx_checker;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        I_CE = 1'b0;
    logic        I_DAT = 1'b0;
    logic [3:0]  O_WORD;
    logic        O_STB;
    logic        LOCKED;
    logic        ERROR;
    logic [15:0] ERR_CNT;

    int checks = 0;
    int failures = 0;

`ifdef OSERDES_RX_CHECKER_STICKY_ERROR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  word;
        logic        locked;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic        stb_due = 1'b0;
    logic        err_latched = 1'b0;
    logic [3:0]  word_exp = '0;
    logic        lock_exp = 1'b0;
    logic        err_exp = 1'b0;
    logic [15:0] cnt_exp = '0;

    oserdes_rx_checker #(.WIDTH(4), .LOCK_CNT(4), .UNLOCK_CNT(2)) dut (
        .CLK(CLK), .RST(RST), .I_CE(I_CE), .I_DAT(I_DAT),
        .O_WORD(O_WORD), .O_STB(O_STB), .LOCKED(LOCKED), .ERROR(ERROR), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    // One clock with the given inputs; pops the scoreboard when a word strobes out.
    task automatic bit_cycle(input logic ce, input logic dat);
        exp_t e;
        I_CE  = ce;
        I_DAT = dat;
        @(posedge CLK);
        #1;
        chk("o_stb", 32'(O_STB), 32'(stb_due));
        err_exp = STICKY & err_latched;
        if (O_STB === 1'b1) begin
            chk("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e        = sb.pop_front();
                word_exp = e.word;
                lock_exp = e.locked;
                cnt_exp  = e.cnt;
                err_exp  = e.err | (STICKY & err_latched);
                if (e.err) err_latched = 1'b1;
            end
        end
        chk("o_word", 32'(O_WORD), 32'(word_exp));
        chk("locked", 32'(LOCKED), 32'(lock_exp));
        chk("error", 32'(ERROR), 32'(err_exp));
        chk("err_cnt", 32'(ERR_CNT), 32'(cnt_exp));
        stb_due = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] v, input logic locked, input logic err,
                             input logic [15:0] cnt, input bit gap);
        exp_t e;
        e.word = v; e.locked = locked; e.err = err; e.cnt = cnt;
        sb.push_back(e);
        for (int i = 3; i >= 0; i--) begin
            if (i == 0) stb_due = 1'b1;
            bit_cycle(1'b1, v[i]);
            if (gap) begin
                bit_cycle(1'b0, 1'($urandom));
                bit_cycle(1'b0, 1'($urandom));
            end
        end
    endtask

    task automatic do_reset(input int n);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        RST = 1'b1;
        err_latched = 1'b0;
        word_exp = '0; lock_exp = 1'b0; cnt_exp = '0;
        for (int i = 0; i < n; i++) bit_cycle(1'b1, 1'($urandom));
        RST = 1'b0;
    endtask

    initial begin
        exp_t e;
        do_reset(3);

        // Aligned ramp from 0, through the 15->0 wrap; lock on word 3.
        for (int i = 0; i < 40; i++) send_word(4'(i), 1'(i >= 3), 1'b0, 16'd0, 1'b0);

        // Single corrupted word: 5 where 6 is due.
        for (int i = 8; i < 22; i++) send_word(4'(i), 1'b1, 1'b0, 16'd0, 1'b0);
        send_word(4'd5, 1'b1, 1'b1, 16'd1, 1'b0);
        send_word(4'd7, 1'b1, 1'b0, 16'd1, 1'b0);
        send_word(4'd8, 1'b1, 1'b0, 16'd1, 1'b0);

        // One junk bit: DUT frames {1,000}=8, slips, then aligns on 9,10,11,12.
        do_reset(2);
        e.word = 4'd8; e.locked = 1'b0; e.err = 1'b0; e.cnt = 16'd0;
        sb.push_back(e);
        bit_cycle(1'b1, 1'b1);
        bit_cycle(1'b1, 1'b0);
        bit_cycle(1'b1, 1'b0);
        stb_due = 1'b1;
        bit_cycle(1'b1, 1'b0);
        bit_cycle(1'b1, 1'b0);
        for (int i = 9; i < 14; i++) send_word(4'(i), 1'(i >= 12), 1'b0, 16'd0, 1'b0);

        // Two bad words unlock; one pad bit absorbs the slip, then relock on 13,14,15,0.
        do_reset(2);
        for (int i = 0; i < 6; i++) send_word(4'(i), 1'(i >= 3), 1'b0, 16'd0, 1'b0);
        send_word(4'd12, 1'b1, 1'b1, 16'd1, 1'b0);
        send_word(4'd12, 1'b0, 1'b1, 16'd2, 1'b0);
        bit_cycle(1'b1, 1'($urandom));
        for (int i = 13; i < 18; i++) send_word(4'(i), 1'(i >= 16), 1'b0, 16'd2, 1'b0);

        // Enable active one cycle in three.
        do_reset(2);
        for (int i = 0; i < 8; i++) send_word(4'(i), 1'(i >= 3), 1'b0, 16'd0, 1'b1);

        // Reset in the middle of a word; the partial word must be discarded.
        bit_cycle(1'b1, 1'b1);
        bit_cycle(1'b1, 1'b0);
        do_reset(1);
        for (int i = 0; i < 6; i++) send_word(4'(i), 1'(i >= 3), 1'b0, 16'd0, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
